clm_mod_p_unit: RTL and testbench

- Final-stage consumer of the CLM datapath, run while the top-level controller is in MOD_P.
- Takes the 16-lane redundant state (state_vec_t, each lane 8+d bits, a polynomial of degree < 8+d) and reduces every lane modulo the base polynomial P to an 8-bit AES byte.
- Packs the 16 bytes into the 128-bit ciphertext bus. The controller moves to PREP_OUTPUT on drdy_o.
- Reduction is iterative: d steps, all 16 lanes in parallel, one step per cycle.

---
 rtl/clm_mod_p_pkg.sv | 30 +++
 rtl/clm_mod_p_step.sv | 27 ++
 rtl/clm_mod_p_unit.sv | 123 ++++++++++++
 tb/tb_clm_mod_p_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clm_mod_p_pkg.sv
// Shared types for the CLM mod-P output stage: lane/state vectors, stage enum,
// counter sizing and the GF(2) 8x8 matrix-vector helper.
package clm_mod_p_pkg;

  localparam int CLM_D          = 4;
  localparam int MOD_P_CTR_BITS = $clog2(CLM_D) + 1;

  // Bit 0 of a lane is the highest-degree coefficient.
  typedef logic [0:7+CLM_D]     state_t;
  typedef state_t [0:3][0:3]    state_vec_t;
  typedef logic [0:8]           base_poly_t;
  typedef logic [7:0][7:0]      mm_matrix_t;

  typedef enum logic [1:0] {
    MP_IDLE,
    MP_REDUCE,
    MP_MAP,
    MP_OUT
  } mod_p_stage_t;

  function automatic logic [7:0] gf2_mv8(input mm_matrix_t m, input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int r = 0; r < 8; r++) begin
      y[r] = ^(m[r] & x);
    end
    return y;
  endfunction

endpackage

// File: rtl/clm_mod_p_step.sv
// One reduction step for a single lane: if coefficient k is set, cancel it by
// XORing P aligned so that P's x^8 term lands on position k.
module clm_mod_p_step
  import clm_mod_p_pkg::*;
#(
  parameter int d        = CLM_D,
  parameter int CTR_BITS = $clog2(d) + 1
) (
  input  logic [0:7+d]         w,
  input  base_poly_t           P,
  input  logic [CTR_BITS-1:0]  k,
  output logic [0:7+d]         w_next
);

  localparam int LW = 8 + d;

  logic [LW-1:0] p_aligned;
  logic [LW-1:0] lead;

  always_comb begin
    p_aligned = LW'(P) << (d - 1);
    p_aligned = p_aligned >> k;
    lead      = {1'b1, {(LW-1){1'b0}}} >> k;
    w_next    = ((w & lead) != '0) ? (w ^ p_aligned) : w;
  end

endmodule

// File: rtl/clm_mod_p_unit.sv
// Reduces all 16 redundant lanes modulo P, one step per cycle, and packs the
// bytes onto the ciphertext bus. Define CLM_MOD_P_LINV_EN to add the L_inv map stage.
module clm_mod_p_unit
  import clm_mod_p_pkg::*;
#(
  parameter int d = CLM_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drdy_i,
  input  logic [0:3][0:3][0:7+d]  in,
  input  base_poly_t              P,
  input  mm_matrix_t              L_inv,
  output logic [127:0]            ciphertext,
  output logic                    drdy_o,
  output logic                    busy
);

  localparam int                  CTR_BITS = $clog2(d) + 1;
  localparam logic [CTR_BITS-1:0] LAST_K   = CTR_BITS'(d - 1);

  mod_p_stage_t            state;
  logic [CTR_BITS-1:0]     ctr;
  logic [0:3][0:3][0:7+d]  w_reg;
  logic [0:3][0:3][0:7+d]  w_step;
  base_poly_t              p_reg;

  for (genvar i = 0; i < 4; i++) begin : g_word
    for (genvar j = 0; j < 4; j++) begin : g_lane
      clm_mod_p_step #(
        .d        (d),
        .CTR_BITS (CTR_BITS)
      ) u_step (
        .w      (w_reg[i][j]),
        .P      (p_reg),
        .k      (ctr),
        .w_next (w_step[i][j])
      );
    end
  end

`ifdef CLM_MOD_P_LINV_EN
  logic [127:0] ct_mapped;

  // The reduced lanes already sit in w_reg by the time MP_MAP runs.
  always_comb begin
    ct_mapped = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ct_mapped[8*(4*i+j) +: 8] = gf2_mv8(L_inv, w_reg[i][j][d +: 8]);
      end
    end
  end
`else
  logic [127:0] ct_reduced;
  logic         unused_linv;

  assign unused_linv = ^L_inv;

  // Packing from the step outputs lets the last reduce edge load the bus directly.
  always_comb begin
    ct_reduced = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ct_reduced[8*(4*i+j) +: 8] = w_step[i][j][d +: 8];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MP_IDLE;
      ctr        <= '0;
      w_reg      <= '0;
      p_reg      <= '0;
      ciphertext <= '0;
      drdy_o     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      drdy_o <= 1'b0;
      case (state)
        MP_IDLE: begin
          if (drdy_i) begin
            w_reg <= in;
            p_reg <= P;
            ctr   <= '0;
            busy  <= 1'b1;
            state <= MP_REDUCE;
          end
        end
        MP_REDUCE: begin
          w_reg <= w_step;
          ctr   <= ctr + CTR_BITS'(1);
          if (ctr == LAST_K) begin
`ifdef CLM_MOD_P_LINV_EN
            state      <= MP_MAP;
`else
            state      <= MP_OUT;
            ciphertext <= ct_reduced;
            drdy_o     <= 1'b1;
`endif
          end
        end
`ifdef CLM_MOD_P_LINV_EN
        MP_MAP: begin
          state      <= MP_OUT;
          ciphertext <= ct_mapped;
          drdy_o     <= 1'b1;
        end
`endif
        MP_OUT: begin
          state <= MP_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= MP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clm_mod_p_unit.sv
// Bench for clm_mod_p_unit: polynomial-remainder model plus hand-computed
// literal bytes; honours CLM_MOD_P_LINV_EN when defined.
module tb_clm_mod_p_unit;

  localparam int D  = 4;
  localparam int LW = 8 + D;
`ifdef CLM_MOD_P_LINV_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D + 1;
`endif

  typedef logic [0:3][0:3][0:LW-1] lanes_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            drdy_i = 1'b0;
  lanes_t          in_v;
  logic [0:8]      p_v;
  logic [7:0][7:0] linv_v;
  logic [127:0]    ciphertext;
  logic            drdy_o;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;
  logic chk_en   = 1'b0;

  int           cnt;
  lanes_t       job_in;
  logic [0:8]   job_p;
  logic [127:0] exp_ct;

  always #5 clk = ~clk;

  clm_mod_p_unit dut (
    .clk        (clk),
    .rst        (rst),
    .drdy_i     (drdy_i),
    .in         (in_v),
    .P          (p_v),
    .L_inv      (linv_v),
    .ciphertext (ciphertext),
    .drdy_o     (drdy_o),
    .busy       (busy)
  );

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Remainder of each lane polynomial by P, optionally mapped through the matrix.
  function automatic logic [127:0] model_ct(input lanes_t lanes, input logic [0:8] p,
                                            input logic [7:0][7:0] m);
    logic [127:0] res;
    logic [11:0]  v;
    logic [11:0]  pp;
    logic [7:0]   b;
    logic [7:0]   y;
    res = '0;
    pp  = {3'b000, p};
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        v = lanes[i][j];
        for (int deg = 11; deg >= 8; deg--) begin
          if (v[deg]) v = v ^ (pp << (deg - 8));
        end
        b = v[7:0];
`ifdef CLM_MOD_P_LINV_EN
        y = '0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            y[r] = y[r] ^ (m[r][c] & b[c]);
`else
        y = b;
`endif
        res[8*(4*i+j) +: 8] = y;
      end
    end
    return res;
  endfunction

  // Job tracker: cnt counts down the busy window of the accepted job.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 0;
      exp_ct <= '0;
    end else if (cnt == 0) begin
      if (drdy_i) begin
        cnt    <= LAT;
        job_in <= in_v;
        job_p  <= p_v;
      end
    end else begin
      cnt <= cnt - 1;
      if (cnt == 2) exp_ct <= model_ct(job_in, job_p, linv_v);
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      check_output("busy", {127'b0, busy}, {127'b0, (cnt > 0)});
      check_output("drdy_o", {127'b0, drdy_o}, {127'b0, (cnt == 1)});
      check_output("ciphertext", ciphertext, exp_ct);
    end
  end

  task automatic apply_stimulus(input lanes_t lanes, input logic [0:8] p);
    @(negedge clk);
    in_v   = lanes;
    p_v    = p;
    drdy_i = 1'b1;
    @(negedge clk);
    drdy_i = 1'b0;
  endtask

  task automatic run_job(input lanes_t lanes, input logic [0:8] p);
    int cyc;
    int busy_cnt;
    apply_stimulus(lanes, p);
    cyc      = 1;
    busy_cnt = busy ? 1 : 0;
    while (!drdy_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
    end
    check_output("drdy_o_seen", {127'b0, drdy_o}, 128'd1);
    check_output("latency", 128'(cyc), 128'(LAT));
    check_output("busy_cycles", 128'(busy_cnt), 128'(LAT));
  endtask

  lanes_t       lanes;
  logic [127:0] exp_lit;
  int           pulses;

  initial begin
    in_v = '0;
    p_v  = 9'h11B;
    for (int r = 0; r < 8; r++) linv_v[r] = 8'h01 << r;

    repeat (3) @(negedge clk);
    check_output("reset_ct", ciphertext, 128'd0);
    check_output("reset_busy", {127'b0, busy}, 128'd0);
    check_output("reset_drdy", {127'b0, drdy_o}, 128'd0);
    rst    = 1'b1;
    chk_en = 1'b1;

    lanes = '0;
    run_job(lanes, 9'h11B);
    check_output("zero_job", ciphertext, 128'd0);

    lanes = '0;
    lanes[0][0] = 12'h100;
    lanes[1][2] = 12'h800;
    lanes[2][1] = 12'h0AB;
    lanes[3][3] = 12'hFFF;
    exp_lit = '0;
    exp_lit[8*0  +: 8] = 8'h1B;
    exp_lit[8*6  +: 8] = 8'hD8;
    exp_lit[8*9  +: 8] = 8'hAB;
    exp_lit[8*15 +: 8] = 8'h66;
    run_job(lanes, 9'h11B);
    check_output("lane_bytes", ciphertext, exp_lit);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        lanes[i][j] = {4'h0, 8'(17*(4*i+j) + 3)};
    run_job(lanes, 9'h11B);
    check_output("pass_through_b5", {120'b0, ciphertext[8*5 +: 8]}, 128'h58);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        lanes[i][j] = 12'($urandom);
    run_job(lanes, 9'h11D);

    // drdy_i held high across a whole job, including the drdy_o cycle.
    lanes = '0;
    lanes[0][0] = 12'h800;
    @(negedge clk);
    in_v   = lanes;
    p_v    = 9'h11B;
    drdy_i = 1'b1;
    pulses = 0;
    for (int n = 1; n <= LAT + 12; n++) begin
      @(negedge clk);
      if (drdy_o) pulses++;
      if (n <= LAT) in_v = lanes_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      else drdy_i = 1'b0;
    end
    check_output("hold_pulses", 128'(pulses), 128'd1);
    check_output("hold_ct", ciphertext, 128'hD8);
    check_output("hold_idle", {127'b0, busy}, 128'd0);

    // Abort during reduce step 2, then a fresh job.
    lanes = '0;
    lanes[1][1] = 12'h100;
    apply_stimulus(lanes, 9'h11B);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("abort_ct", ciphertext, 128'd0);
    check_output("abort_drdy", {127'b0, drdy_o}, 128'd0);
    check_output("abort_busy", {127'b0, busy}, 128'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    lanes = '0;
    lanes[0][0] = 12'h100;
    lanes[1][2] = 12'h800;
    lanes[2][1] = 12'h0AB;
    lanes[3][3] = 12'hFFF;
    run_job(lanes, 9'h11B);
    check_output("post_abort", ciphertext, exp_lit);

`ifdef CLM_MOD_P_LINV_EN
    for (int r = 0; r < 8; r++) linv_v[r] = 8'h01 << (7 - r);
    lanes = '0;
    lanes[0][0] = 12'h100;
    run_job(lanes, 9'h11B);
    check_output("linv_reverse", ciphertext, 128'hD8);
`endif

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
